// File: rtl/alu_flag_unit_pkg.sv
// Shared constants for the ALU status-flag block: condition codes and flag packing order.
package alu_flag_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Signed overflow from operand/result sign bits; b_msb is the un-inverted operand B.
  function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    ovf_calc = (sub ? (a_msb != b_msb) : (a_msb == b_msb)) & (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_flag_unit_if.sv
// ALU-side bus into the flag unit: result/operand status in, zero/flags/condition out.
interface alu_flag_unit_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] result;
  logic             a_msb;
  logic             b_msb;
  logic             carry_out;
  logic             sub;
  logic             arith;
  logic             flag_write;
  logic [3:0]       cond;
  logic             zero;
  logic             z_flag;
  logic             n_flag;
  logic             c_flag;
  logic             v_flag;
  logic             flag_valid;
  logic             cond_pass;

  modport master (
    output result, a_msb, b_msb, carry_out, sub, arith, flag_write, cond,
    input  zero, z_flag, n_flag, c_flag, v_flag, flag_valid, cond_pass
  );

  modport slave (
    input  result, a_msb, b_msb, carry_out, sub, arith, flag_write, cond,
    output zero, z_flag, n_flag, c_flag, v_flag, flag_valid, cond_pass
  );
endinterface

// File: rtl/alu_flag_unit_cond_eval.sv
// ARM-style condition-code evaluator over a packed ZNCV vector; shared with the branch unit.
module alu_flag_unit_cond_eval
  import alu_flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic z, n, c, v;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_flag_unit.sv
// Zero detect, ZNCV flag register and condition evaluation sitting between ALU and control.
module alu_flag_unit
  import alu_flag_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit BYPASS = 1'b0
) (
  input logic            clk,
  input logic            reset,
  alu_flag_unit_if.slave bus
);
  logic [3:0] flags_q;
  logic [3:0] flags_n;
  logic [3:0] flags_src;
  logic       valid_q;
  logic       r_msb;

  // Live zero feeds beq/bne in the same instruction, so it bypasses the register entirely.
  assign bus.zero = ~|bus.result;
  assign r_msb    = bus.result[WIDTH-1];

  always_comb begin
    flags_n         = flags_q;
    flags_n[FLAG_Z] = bus.zero;
    flags_n[FLAG_N] = r_msb;
    if (bus.arith) begin
      flags_n[FLAG_C] = bus.carry_out;
      flags_n[FLAG_V] = ovf_calc(bus.sub, bus.a_msb, bus.b_msb, r_msb);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      valid_q <= 1'b0;
    end else if (bus.flag_write) begin
      flags_q <= flags_n;
      valid_q <= 1'b1;
    end
  end

  assign flags_src = (BYPASS && bus.flag_write) ? flags_n : flags_q;

  alu_flag_unit_cond_eval u_cond_eval (
    .cond  (bus.cond),
    .flags (flags_src),
    .pass  (bus.cond_pass)
  );

  assign bus.z_flag     = flags_q[FLAG_Z];
  assign bus.n_flag     = flags_q[FLAG_N];
  assign bus.c_flag     = flags_q[FLAG_C];
  assign bus.v_flag     = flags_q[FLAG_V];
  assign bus.flag_valid = valid_q;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed vector bench for alu_flag_unit, running BYPASS=0 and BYPASS=1 side by side.
module tb_alu_flag_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  alu_flag_unit_if #(.WIDTH(8)) bus0 ();
  alu_flag_unit_if #(.WIDTH(8)) bus1 ();

  alu_flag_unit #(.WIDTH(8), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_flag_unit #(.WIDTH(8), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus1.result     = bus0.result;
  assign bus1.a_msb      = bus0.a_msb;
  assign bus1.b_msb      = bus0.b_msb;
  assign bus1.carry_out  = bus0.carry_out;
  assign bus1.sub        = bus0.sub;
  assign bus1.arith      = bus0.arith;
  assign bus1.flag_write = bus0.flag_write;
  assign bus1.cond       = bus0.cond;

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] res;
    logic       a, b, co, sub, ar, fw;
    logic [3:0] cond;
    logic       zero, p0, p1;   // pre-edge: live zero, cond_pass for BYPASS=0 / BYPASS=1
    logic [3:0] flags;          // post-edge ZNCV
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [7:0] res, logic a, logic b, logic co,
                              logic sub, logic ar, logic fw, logic [3:0] cond,
                              logic zero, logic p0, logic p1, logic [3:0] flags, logic valid);
    vec_t v;
    v.rst = rst; v.res = res; v.a = a; v.b = b; v.co = co; v.sub = sub; v.ar = ar;
    v.fw = fw; v.cond = cond; v.zero = zero; v.p0 = p0; v.p1 = p1; v.flags = flags;
    v.valid = valid;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_of0();
    return {bus0.z_flag, bus0.n_flag, bus0.c_flag, bus0.v_flag};
  endfunction
  function automatic logic [3:0] flags_of1();
    return {bus1.z_flag, bus1.n_flag, bus1.c_flag, bus1.v_flag};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //       rst res    a  b  co sub ar fw cond   zero p0 p1 ZNCV     valid
    vecs.push_back(mk(0, 8'h55, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 8'h55, 0, 0, 0, 0, 0, 0, 4'hE, 0, 1, 1, 4'b0000, 0));
    vecs.push_back(mk(0, 8'h55, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 8'h55, 0, 0, 0, 0, 0, 0, 4'h1, 0, 1, 1, 4'b0000, 0));
    // zero capture on subtract
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 1, 4'h0, 1, 0, 1, 4'b1010, 1));
    vecs.push_back(mk(0, 8'h12, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 4'b1010, 1));
    vecs.push_back(mk(0, 8'h12, 0, 0, 0, 0, 0, 0, 4'h8, 0, 0, 0, 4'b1010, 1));
    // 0x7F + 0x01 overflow
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 1, 1, 4'h6, 0, 0, 1, 4'b0101, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 0, 4'hA, 0, 1, 1, 4'b0101, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 0, 4'hB, 0, 0, 0, 4'b0101, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 0, 4'h6, 0, 1, 1, 4'b0101, 1));
    // 0x05 - 0x07 borrow
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 1, 1, 1, 4'h3, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h3, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'hB, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h9, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'hC, 0, 0, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'hD, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h4, 0, 1, 1, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h2, 0, 0, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 8'hFE, 0, 0, 0, 0, 0, 0, 4'h7, 0, 1, 1, 4'b0100, 1));
    // 0x80 - 0x01: C=1, V=1
    vecs.push_back(mk(0, 8'h7F, 1, 0, 1, 1, 1, 1, 4'h8, 0, 0, 1, 4'b0011, 1));
    // hold for three cycles while result is zero
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 4'b0011, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 4'b0011, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0, 4'b0011, 1));
    // logical op: N updates, C/V retained
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 1, 4'h4, 0, 0, 1, 4'b0111, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 0, 4'hA, 0, 1, 1, 4'b0111, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 0, 0, 0, 4'h2, 0, 1, 1, 4'b0111, 1));
    // reset wins over a pending write
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1, 1, 4'h0, 1, 0, 1, 4'b0000, 0));
    // bypass: EQ seen in the write cycle only with BYPASS=1
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 4'h0, 1, 0, 1, 4'b1000, 1));
    vecs.push_back(mk(0, 8'h01, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 4'b1000, 1));

    // reset held for two edges
    reset = 1'b1;
    bus0.result = 8'h55; bus0.a_msb = 1'b0; bus0.b_msb = 1'b0; bus0.carry_out = 1'b0;
    bus0.sub = 1'b0; bus0.arith = 1'b0; bus0.flag_write = 1'b0; bus0.cond = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags0", -1, flags_of0(), 4'b0000);
    chk("reset_flags1", -1, flags_of1(), 4'b0000);
    chk("reset_valid0", -1, {3'b0, bus0.flag_valid}, 4'b0000);
    chk("reset_valid1", -1, {3'b0, bus1.flag_valid}, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset            = vecs[i].rst;
      bus0.result      = vecs[i].res;
      bus0.a_msb       = vecs[i].a;
      bus0.b_msb       = vecs[i].b;
      bus0.carry_out   = vecs[i].co;
      bus0.sub         = vecs[i].sub;
      bus0.arith       = vecs[i].ar;
      bus0.flag_write  = vecs[i].fw;
      bus0.cond        = vecs[i].cond;
      #1;
      chk("zero", i, {3'b0, bus0.zero}, {3'b0, vecs[i].zero});
      chk("pass_byp0", i, {3'b0, bus0.cond_pass}, {3'b0, vecs[i].p0});
      chk("pass_byp1", i, {3'b0, bus1.cond_pass}, {3'b0, vecs[i].p1});
      @(posedge clk);
      #1;
      chk("flags0", i, flags_of0(), vecs[i].flags);
      chk("flags1", i, flags_of1(), vecs[i].flags);
      chk("valid0", i, {3'b0, bus0.flag_valid}, {3'b0, vecs[i].valid});
    end

    // live zero follows result with no clock edge
    @(negedge clk);
    bus0.flag_write = 1'b0;
    bus0.result = 8'h00;
    #1 chk("zero_live_0", -1, {3'b0, bus0.zero}, 4'b0001);
    bus0.result = 8'h40;
    #1 chk("zero_live_1", -1, {3'b0, bus0.zero}, 4'b0000);
    bus0.result = 8'h00;
    #1 chk("zero_live_2", -1, {3'b0, bus0.zero}, 4'b0001);
    chk("z_unchanged", -1, flags_of0(), 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Parametrised successor to the 8-input zero-detect NOR.
- Derives Zero, Negative, Carry and oVerflow status from a WIDTH-bit ALU result and holds them in a flag register.
- Evaluates ARM-style 4-bit condition codes against the held flags.
- Sits between the ALU and the control unit: live ZERO drives beq/bne in the current instruction; registered flags and COND_PASS drive conditional execution in later instructions.

Parameters:
- WIDTH, 8: ALU result width in bits; must be >= 2.
- BYPASS, 0: when 1, COND_PASS is evaluated on next-state flags if FLAG_WRITE is high in the same cycle; when 0, COND_PASS always uses registered flags.

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  synchronous, active-high reset.
- RESULT  input  WIDTH  ALU result.
- A_MSB  input  1  sign bit of ALU operand A.
- B_MSB  input  1  sign bit of ALU operand B, before any inversion for subtract.
- CARRY_OUT  input  1  adder carry out. For subtract this is the carry of A+~B+1 (ARM convention: 1 = no borrow).
- SUB  input  1  1 = subtract operation, 0 = add or logical.
- ARITH  input  1  1 = arithmetic op. When 0, C and V hold their registered values.
- FLAG_WRITE  input  1  capture flags at the next rising edge.
- COND  input  4  condition code to evaluate.
- ZERO  output  1  combinational NOR of all RESULT bits.
- Z_FLAG, N_FLAG, C_FLAG, V_FLAG  output  1 each  registered flags.
- FLAG_VALID  output  1  set after the first flag write since reset.
- COND_PASS  output  1  condition satisfied.

Behaviour:
- Reset values: RESET is sampled on the rising CLK edge only. Z/N/C/V_FLAG = 0, FLAG_VALID = 0. RESET has priority over FLAG_WRITE in the same cycle.
- ZERO: pure combinational, zero latency, equals 1 iff RESULT == 0. It does not depend on CLK, RESET or FLAG_WRITE.
- Next-state flags:
  - z_n = ZERO
  - n_n = RESULT[WIDTH-1]
  - c_n = ARITH ? CARRY_OUT : C_FLAG
  - v_n = ARITH ? vcalc : V_FLAG
  - add: vcalc = (A_MSB == B_MSB) & (RESULT[WIDTH-1] != A_MSB)
  - sub: vcalc = (A_MSB != B_MSB) & (RESULT[WIDTH-1] != A_MSB)
- Latency: with FLAG_WRITE = 1 at edge k, the next-state values appear on the *_FLAG outputs after edge k, and FLAG_VALID goes to 1 and stays at 1 until reset.
- Hold: with FLAG_WRITE = 0, all flags hold regardless of RESULT.
- Condition codes (0x0 to 0xF):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 0xF (NV) 0
- COND_PASS source: purely combinational from COND and the flag source. The flag source is the registered flags, or the next-state flags when BYPASS = 1 and FLAG_WRITE = 1.
- Flag validity: while FLAG_VALID = 0, COND_PASS is still computed on the reset flags (all 0). For example, NE = 1 and EQ = 0 after reset.
- Reset mid-operation: a pending FLAG_WRITE is discarded. No partial update of any flag.

Decomposition:
- Shared package:
  - 4-bit condition-code constants COND_EQ through COND_NV.
  - Flag bit-index constants FLAG_Z = 3, FLAG_N = 2, FLAG_C = 1, FLAG_V = 0, for packing flags as a 4-bit vector.
- Sub-module cond_eval: combinational; inputs are COND and the 4 flags, output is pass. It is reused later by the branch unit.
- Zero detect is an inline reduction NOR over WIDTH bits. No separate module.

Test Plan (WIDTH = 8):
1. Reset: hold RESET = 1 for 2 edges -> all flags 0, FLAG_VALID = 0; COND = 0x0 (EQ) -> COND_PASS = 0; COND = 0xE -> 1; COND = 0xF -> 0.
2. Zero capture: RESULT = 0x00, ARITH = 1, SUB = 1, CARRY_OUT = 1, FLAG_WRITE = 1 -> ZERO = 1 immediately. After the edge: Z = 1, C = 1, N = 0, V = 0, FLAG_VALID = 1. EQ passes, HI fails.
3. Signed overflow on add: 0x7F+0x01, RESULT = 0x80, A_MSB = 0, B_MSB = 0, CARRY_OUT = 0, SUB = 0, ARITH = 1, write -> N = 1, V = 1, C = 0, Z = 0. GE (0xA) passes, LT (0xB) fails, VS passes.
4. Borrow on subtract: 0x05-0x07, RESULT = 0xFE, A_MSB = 0, B_MSB = 0, CARRY_OUT = 0, SUB = 1, write -> N = 1, C = 0, V = 0. CC (0x3) passes, LT passes, LS passes.
5. Hold and logical ops:
   - FLAG_WRITE = 0, RESULT = 0x00 -> ZERO = 1 but Z_FLAG unchanged for 3 cycles.
   - Then ARITH = 0, RESULT = 0x80, write -> N = 1, and C and V retain their prior values.
6. Reset priority and bypass:
   - RESET = 1 together with FLAG_WRITE = 1, RESULT = 0x00 -> flags 0, FLAG_VALID = 0.
   - With BYPASS = 1, FLAG_WRITE = 1, RESULT = 0x00, COND = EQ -> COND_PASS = 1 in the same cycle. With BYPASS = 0 the same stimulus gives COND_PASS = 0 until after the edge.
